// File: rtl/fetch_decode_pkg.sv
`default_nettype none
//==============================================================================
// fetch_decode_pkg - shared fetch-to-decode packet type and queue defaults
// Revision: 1.0
//==============================================================================
package fetch_decode_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_to_decode_packet_t;

  localparam int FTD_DATA_WIDTH  = $bits(fetch_to_decode_packet_t);
  localparam int FTD_QUEUE_DEPTH = 4;

endpackage
`default_nettype wire

// File: rtl/ftd_queue_storage.sv
`default_nettype none
//==============================================================================
// ftd_queue_storage - DEPTH x DATA_WIDTH register array, async read port
// Revision: 1.0
//==============================================================================
module ftd_queue_storage
  import fetch_decode_pkg::*;
#(
  parameter int DATA_WIDTH = FTD_DATA_WIDTH,
  parameter int DEPTH      = FTD_QUEUE_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Contents are deliberately left unreset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_to_decode_queue.sv
`default_nettype none
//==============================================================================
// fetch_to_decode_queue - fetch->decode packet FIFO with flush and error flag
// Revision: 1.0
//==============================================================================
module fetch_to_decode_queue
  import fetch_decode_pkg::*;
#(
  parameter int DATA_WIDTH      = FTD_DATA_WIDTH,
  parameter int DEPTH           = FTD_QUEUE_DEPTH,
  parameter int ALMOST_FULL_LVL = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    almost_full,
  output logic                    protocol_err
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_af   = c_cw'(ALMOST_FULL_LVL);

  logic [c_aw-1:0]       r_wr_ptr;
  logic [c_aw-1:0]       r_rd_ptr;
  logic [c_cw-1:0]       r_count;
  logic [c_cw-1:0]       w_count_nxt;
  logic                  r_almost_full;
  logic                  r_protocol_err;
  logic                  r_stall_pend;
  logic [DATA_WIDTH-1:0] r_stall_data;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_stall_viol;

  assign in_ready     = (r_count != c_full);
  assign out_valid    = (r_count != '0);
  assign w_push       = in_valid && in_ready;
  assign w_pop        = out_valid && out_ready;
  assign out_data     = out_valid ? w_head : '0;
  assign count        = r_count;
  assign almost_full  = r_almost_full;
  assign protocol_err = r_protocol_err;

  // A flush discards the stalled packet, so the producer may withdraw it freely.
  assign w_stall_viol = r_stall_pend && !flush &&
                        (!in_valid || (in_data != r_stall_data));

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_almost_full  <= 1'b0;
      r_protocol_err <= 1'b0;
      r_stall_pend   <= 1'b0;
      r_stall_data   <= '0;
    end else begin
      r_count       <= w_count_nxt;
      r_almost_full <= (w_count_nxt >= c_af);
      r_stall_pend  <= !flush && in_valid && !in_ready;
      r_stall_data  <= in_data;
      if (w_stall_viol) begin
        r_protocol_err <= 1'b1;
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
    end
  end

  ftd_queue_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (c_aw)
  ) u_storage (
    .clk   (clk),
    .we    (w_push && !flush),
    .waddr (r_wr_ptr),
    .wdata (in_data),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_to_decode_queue.sv
`default_nettype none
//==============================================================================
// tb_fetch_to_decode_queue - directed + random bench against a queue model
// Revision: 1.0
//==============================================================================
module tb_fetch_to_decode_queue;

  localparam int DW = 96;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [2:0]    count;
  logic          almost_full;
  logic          protocol_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  fetch_to_decode_queue dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count),
    .almost_full  (almost_full),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  // Reference: a plain queue of packets plus the error/stall bookkeeping
  logic [DW-1:0] mq[$];
  bit            m_err;
  bit            m_stall;
  logic [DW-1:0] m_stall_d;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_err   = 1'b0;
      m_stall = 1'b0;
      m_stall_d = '0;
    end else begin
      bit full, push, pop;
      full = (mq.size() == 4);
      push = in_valid && !full;
      pop  = (mq.size() != 0) && out_ready;
      if (m_stall && !flush && (!in_valid || in_data != m_stall_d)) m_err = 1'b1;
      m_stall   = !flush && in_valid && full;
      m_stall_d = in_data;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(in_data);
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m.count",        DW'(count),        DW'(mq.size()));
      chk("m.in_ready",     DW'(in_ready),     DW'(mq.size() != 4));
      chk("m.out_valid",    DW'(out_valid),    DW'(mq.size() != 0));
      chk("m.out_data",     out_data,          (mq.size() != 0) ? mq[0] : '0);
      chk("m.almost_full",  DW'(almost_full),  DW'(mq.size() >= 3));
      chk("m.protocol_err", DW'(protocol_err), DW'(m_err));
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit rdy, input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".count"},        DW'(count),        '0);
    chk({tag, ".in_ready"},     DW'(in_ready),     DW'(1));
    chk({tag, ".out_valid"},    DW'(out_valid),    '0);
    chk({tag, ".out_data"},     out_data,          '0);
    chk({tag, ".almost_full"},  DW'(almost_full),  '0);
    chk({tag, ".protocol_err"}, DW'(protocol_err), '0);
  endtask

  logic [DW-1:0] exp_order [4];
  bit hold;

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset_n  = 1'b1;
    check_en = 1'b1;

    // Fill with A1..A3, decode stalled
    drive(1, 96'hA1, 0, 0); @(negedge clk);
    chk("fill1.count", DW'(count), 96'd1);
    chk("fill1.out_data", out_data, 96'hA1);
    drive(1, 96'hA2, 0, 0); @(negedge clk);
    chk("fill2.count", DW'(count), 96'd2);
    drive(1, 96'hA3, 0, 0); @(negedge clk);
    chk("fill3.count", DW'(count), 96'd3);
    chk("fill3.almost_full", DW'(almost_full), 96'd1);
    chk("fill3.head", out_data, 96'hA1);
    drive(1, 96'hA4, 0, 0); @(negedge clk);
    chk("full.in_ready", DW'(in_ready), 96'd0);

    // Stall B5 at full, single pop, then B5 enters
    drive(1, 96'hB5, 0, 0); @(negedge clk);
    chk("stall.count", DW'(count), 96'd4);
    drive(1, 96'hB5, 1, 0); @(negedge clk);
    chk("pop1.count", DW'(count), 96'd3);
    chk("pop1.head", out_data, 96'hA2);
    drive(1, 96'hB5, 0, 0); @(negedge clk);
    chk("b5in.count", DW'(count), 96'd4);
    exp_order[0] = 96'hA2; exp_order[1] = 96'hA3;
    exp_order[2] = 96'hA4; exp_order[3] = 96'hB5;
    drive(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain.order", out_data, exp_order[i]);
      @(negedge clk);
    end
    chk("drain.empty", DW'(out_valid), 96'd0);

    // Streaming with pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1, DW'(32'h100 + i), 1, 0); @(negedge clk);
      chk("stream.count", DW'(count), 96'd1);
      chk("stream.data", out_data, DW'(32'h100 + i));
    end
    drive(0, '0, 1, 0); @(negedge clk);

    // Flush beats a simultaneous push and pop
    drive(1, 96'hE1, 0, 0); @(negedge clk);
    drive(1, 96'hE2, 0, 0); @(negedge clk);
    drive(1, 96'hE3, 0, 0); @(negedge clk);
    chk("preflush.count", DW'(count), 96'd3);
    drive(1, 96'hC0, 1, 1); @(negedge clk);
    chk("flush.count", DW'(count), 96'd0);
    chk("flush.out_valid", DW'(out_valid), 96'd0);
    drive(0, '0, 1, 0);
    repeat (2) @(negedge clk);
    chk("postflush.out_valid", DW'(out_valid), 96'd0);

    // Producer changes a stalled packet
    for (int i = 0; i < 4; i++) begin
      drive(1, DW'(8'hF0 + i), 0, 0); @(negedge clk);
    end
    drive(1, 96'hD0, 0, 0); @(negedge clk);
    chk("stallD0.err", DW'(protocol_err), 96'd0);
    drive(1, 96'hD1, 0, 0); @(negedge clk);
    chk("stallD1.err", DW'(protocol_err), 96'd1);
    drive(0, '0, 0, 1); @(negedge clk);
    chk("errflush.err", DW'(protocol_err), 96'd1);
    drive(1, 96'h61, 0, 0); @(negedge clk);
    drive(1, 96'h62, 0, 0); @(negedge clk);
    drive(0, '0, 0, 0);
    chk("prerst.count", DW'(count), 96'd2);

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 96'h77, 0, 0); @(negedge clk);
    chk("postrst.data", out_data, 96'h77);
    chk("postrst.count", DW'(count), 96'd1);
    drive(0, '0, 1, 0); @(negedge clk);

    // Randomized traffic with a handshake-compliant producer
    hold = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom, $urandom};
      end
      out_ready = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      hold      = in_valid && !in_ready;
      @(negedge clk);
    end
    drive(0, '0, 0, 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_to_decode_queue.md
Name: fetch_to_decode_queue

Overview:
Parametrised, multi-entry successor to the single-slot fetch-to-decode bus. A synchronous FIFO of fetch packets between the fetch and decode stages, with valid/ready handshakes on both sides. Adds a pipeline flush for branch redirect, an occupancy count and a sticky protocol-error flag. Fetch can run ahead of decode by up to DEPTH packets.

Parameters:
DATA_WIDTH, 96, width in bits of one packed fetch-to-decode packet.
DEPTH, 4, number of entries; power of two, at least 2.
ALMOST_FULL_LVL, DEPTH-1, count at or above which almost_full asserts; range 1..DEPTH.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
flush  in  1  discard all queued packets (branch redirect).
in_valid  in  1  fetch presents a packet.
in_ready  out  1  queue can accept a packet this cycle.
in_data  in  DATA_WIDTH  packet from fetch.
out_valid  out  1  head packet available to decode.
out_ready  in  1  decode consumes the head packet this cycle.
out_data  out  DATA_WIDTH  head packet.
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
almost_full  out  1  count >= ALMOST_FULL_LVL.
protocol_err  out  1  sticky; producer broke handshake stability.

Behaviour:
- Reset: asynchronous assert on reset_n low. Clears rd_ptr, wr_ptr and count to 0. Reset values: in_ready=1, out_valid=0, out_data=0, count=0, almost_full=0, protocol_err=0. Storage contents are not reset. Reset asserted mid-transfer drops all entries; no partial state survives.
- Push: occurs when in_valid && in_ready at the edge. Writes in_data to mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap, pointer width $clog2(DEPTH)).
- Pop: occurs when out_valid && out_ready at the edge. rd_ptr increments modulo DEPTH.
- in_ready = (count != DEPTH).
  - Combinational from registered count only; no dependence on out_ready.
  - A full queue does not accept a push in the same cycle as a pop.
- out_valid = (count != 0). out_data = mem[rd_ptr], read combinationally from registered state.
- Latency: a packet pushed at edge N is visible on out_valid/out_data after edge N. Minimum fetch-to-decode latency is 1 cycle; there is no same-cycle bypass.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; legal whenever 0 < count < DEPTH.
  - At count==0 only a push can occur; at count==DEPTH only a pop can occur.
- Ordering: strict FIFO; no reordering and no duplication.
- flush: takes priority over push and pop in the same cycle.
  - Next state: rd_ptr=wr_ptr=0, count=0.
  - A simultaneous push is discarded; a simultaneous pop is treated as not having occurred.
  - in_ready remains driven from count, so it is 1 during flush unless the queue was full.
- protocol_err:
  - Sets when, in the previous cycle, in_valid=1 and in_ready=0, and in the current cycle in_valid falls or in_data changes.
  - The stalled-packet check is cleared by flush.
  - protocol_err itself clears only on reset.
  - Replaces the "send while busy" assertion of the single-slot bus.
- almost_full: registered compare, updated with count; intended for fetch-side throttling one cycle early.
- No combinational path from in_valid to out_valid, nor from out_ready to in_ready.

Decomposition:
- Shared package fetch_decode_pkg: the fetch_to_decode_packet_t struct, FTD_DATA_WIDTH derived from $bits of that struct, and FTD_QUEUE_DEPTH default constant.
- One natural sub-module, ftd_queue_storage: a DEPTH x DATA_WIDTH register array with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- Pointer, count and flag logic stay in the top.

Test Plan:
- Reset, then push packets 0xA1, 0xA2, 0xA3 on consecutive cycles with out_ready=0 → count 1,2,3; almost_full=1 at count 3; out_data=0xA1 from the cycle after the first push.
- Fill to 4, hold in_valid=1 with 0xB5 → in_ready=0 and count stays 4. Then pulse out_ready for one cycle → pops 0xA1, count=3. 0xB5 is accepted on the next edge; order A2, A3, A4, B5 is preserved.
- Steady streaming with in_valid=out_ready=1 for 20 cycles, including pointer wrap → count constant at 1, every packet emerges exactly once, in order, 1 cycle after its push.
- With count=3, assert flush together with a push of 0xC0 and a pop → next cycle count=0, out_valid=0, 0xC0 never appears at the output.
- Stall at full, then change in_data from 0xD0 to 0xD1 while in_ready=0 → protocol_err=1 the following cycle; it remains 1 through a flush; reset_n low clears it.
- Assert reset_n low asynchronously, mid-cycle, with count=2 → outputs take their reset values immediately without a clock edge; after release, the first push produces out_data equal to that packet.
